// File: rtl/subtractor_serial_nbit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : subtractor_serial_nbit_pkg
// Brief    : State encodings and counter sizing for the bit-serial subtractor.
// Revision : 1.0 - initial release
// ============================================================================
package subtractor_serial_nbit_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Bit counter only needs to reach WIDTH-1.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/full_subtractor_df.sv
`default_nettype none
// ============================================================================
// Module   : full_subtractor_df
// Brief    : Combinational 1-bit full subtractor, dataflow form.
// Revision : 1.0 - initial release
// ============================================================================
module full_subtractor_df (
    output logic d,
    output logic bo,
    input  logic a,
    input  logic b,
    input  logic bi
);

    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule
`default_nettype wire

// File: rtl/subtractor_serial_nbit.sv
`default_nettype none
// ============================================================================
// Module   : subtractor_serial_nbit
// Brief    : Bit-serial N-bit subtractor d = a - b - bi, LSB first.
// Revision : 1.0 - initial release
// ============================================================================
module subtractor_serial_nbit
    import subtractor_serial_nbit_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo,
    output logic             ovf
);

    localparam int              CW         = cnt_width(WIDTH);
    localparam logic [CW-1:0]   c_last_cnt = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] rs;
    logic             br;
    logic             sa;
    logic             sb;
    logic [CW-1:0]    cnt;

    logic             w_diff;
    logic             w_bo;
    logic             w_last;
    logic             w_accept;

    full_subtractor_df u_cell (
        .d  (w_diff),
        .bo (w_bo),
        .a  (ra[0]),
        .b  (rb[0]),
        .bi (br)
    );

    assign w_last   = (cnt == c_last_cnt);
    assign w_accept = (state != S_RUN) && start;
    assign busy     = (state == S_RUN);
    assign done     = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: state_nxt = start ? S_RUN : S_IDLE;
            S_RUN:          state_nxt = w_last ? S_DONE : S_RUN;
            default:        state_nxt = S_IDLE;
        endcase
    end

    // Operand shifters, borrow flop and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            ra  <= '0;
            rb  <= '0;
            rs  <= '0;
            br  <= 1'b0;
            sa  <= 1'b0;
            sb  <= 1'b0;
            cnt <= '0;
            d   <= '0;
            bo  <= 1'b0;
            ovf <= 1'b0;
        end else if (w_accept) begin
            ra  <= a;
            rb  <= b;
            br  <= bi;
            sa  <= a[WIDTH-1];
            sb  <= b[WIDTH-1];
            cnt <= '0;
        end else if (state == S_RUN) begin
            ra  <= ra >> 1;
            rb  <= rb >> 1;
            br  <= w_bo;
            rs  <= {w_diff, rs[WIDTH-1:1]};
            cnt <= cnt + 1'b1;
            if (w_last) begin
                // Final bit is the result MSB, so it feeds the overflow term directly.
                d   <= {w_diff, rs[WIDTH-1:1]};
                bo  <= w_bo;
                ovf <= (sa ^ sb) & (sa ^ w_diff);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_subtractor_serial_nbit.sv
`default_nettype none
// ============================================================================
// Module   : tb_subtractor_serial_nbit
// Brief    : Scoreboarded bench for the bit-serial subtractor at WIDTH 4 and 8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_subtractor_serial_nbit;

    typedef struct packed {
        logic [7:0] d;
        logic       bo;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start4, start8;
    logic [3:0] a4, b4;
    logic [7:0] a8, b8;
    logic       bi4, bi8;
    logic       busy4, done4, bo4, ovf4;
    logic       busy8, done8, bo8, ovf8;
    logic [3:0] d4;
    logic [7:0] d8;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb4[$];
    exp_t sb8[$];

    always #5 clk = ~clk;

    subtractor_serial_nbit #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bi(bi4),
        .busy(busy4), .done(done4), .d(d4), .bo(bo4), .ovf(ovf4)
    );

    subtractor_serial_nbit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bi(bi8),
        .busy(busy8), .done(done8), .d(d8), .bo(bo8), .ovf(ovf8)
    );

    // Arithmetic reference: wrapped difference, unsigned borrow, signed overflow.
    // Note 9-3 at WIDTH=4 is -7-3 in two's complement, so ovf=1 there.
    function automatic exp_t model(input int w, input int a, input int b, input int bi);
        exp_t e;
        int   diff, mask, msa, msb, msd;
        diff  = a - b - bi;
        mask  = (1 << w) - 1;
        e.d   = 8'(diff & mask);
        e.bo  = (diff < 0);
        msa   = (a >> (w - 1)) & 1;
        msb   = (b >> (w - 1)) & 1;
        msd   = ((diff & mask) >> (w - 1)) & 1;
        e.ovf = (msa != msb) && (msd != msa);
        return e;
    endfunction

    // Called at a negedge; start is high across exactly one rising edge.
    task automatic drive4(input int a, input int b, input int bi, input bit accept);
        a4 = 4'(a); b4 = 4'(b); bi4 = 1'(bi); start4 = 1'b1;
        if (accept) sb4.push_back(model(4, a, b, bi));
        @(negedge clk);
        start4 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom); bi4 = 1'($urandom);
    endtask

    task automatic drive8(input int a, input int b, input int bi);
        a8 = 8'(a); b8 = 8'(b); bi8 = 1'(bi); start8 = 1'b1;
        sb8.push_back(model(8, a, b, bi));
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
    endtask

    task automatic wait_done4(input int limit, output int cyc, output bit seen);
        seen = 1'b0; cyc = 0;
        while (cyc < limit && !seen) begin
            @(negedge clk);
            cyc++;
            if (done4 === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic wait_done8(input int limit, output int cyc, output bit seen);
        seen = 1'b0; cyc = 0;
        while (cyc < limit && !seen) begin
            @(negedge clk);
            cyc++;
            if (done8 === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start4 = 1'b0; start8 = 1'b0;
        a4 = '0; b4 = '0; bi4 = 1'b0; a8 = '0; b8 = '0; bi8 = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({busy4, done4, d4, bo4, ovf4} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_w4: got busy=%b done=%b d=%h bo=%b ovf=%b, want all 0",
                     busy4, done4, d4, bo4, ovf4);
        end
        n_tests++;
        if ({busy8, done8, d8, bo8, ovf8} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_w8: got busy=%b done=%b d=%h bo=%b ovf=%b, want all 0",
                     busy8, done8, d8, bo8, ovf8);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int   va[4]  = '{9, 3, 8, 0};
        int   vb[4]  = '{3, 5, 1, 0};
        int   vbi[4] = '{0, 0, 0, 1};
        int   cyc;
        bit   seen;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive4(va[i], vb[i], vbi[i], 1'b1);
            n_tests++;
            if (busy4 !== 1'b1 || done4 !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_busy[%0d]: got busy=%b done=%b, want busy=1 done=0", i, busy4, done4);
            end
            wait_done4(10, cyc, seen);
            n_tests++;
            if (!seen || cyc != 4) begin
                n_fail++;
                $display("FAIL basic_latency[%0d]: got seen=%b cycles=%0d, want done after 4", i, seen, cyc);
            end
            e = sb4.pop_front();
            n_tests++;
            if (d4 !== e.d[3:0] || bo4 !== e.bo || ovf4 !== e.ovf || busy4 !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_result[%0d]: got d=%0d bo=%b ovf=%b busy=%b, want d=%0d bo=%b ovf=%b busy=0",
                         i, d4, bo4, ovf4, busy4, e.d[3:0], e.bo, e.ovf);
            end
            @(negedge clk);
            n_tests++;
            if (done4 !== 1'b0 || busy4 !== 1'b0 || d4 !== e.d[3:0] || bo4 !== e.bo || ovf4 !== e.ovf) begin
                n_fail++;
                $display("FAIL basic_hold[%0d]: got done=%b busy=%b d=%0d bo=%b ovf=%b, want done=0 busy=0 d=%0d bo=%b ovf=%b",
                         i, done4, busy4, d4, bo4, ovf4, e.d[3:0], e.bo, e.ovf);
            end
        end
    endtask

    task automatic test_back_to_back;
        int   cyc;
        bit   seen;
        exp_t e;
        @(negedge clk);
        drive4(9, 3, 0, 1'b1);
        @(negedge clk);
        drive4(1, 1, 0, 1'b0);
        wait_done4(10, cyc, seen);
        n_tests++;
        if (!seen || cyc != 2) begin
            n_fail++;
            $display("FAIL ignore_latency: got seen=%b cycles=%0d, want done 2 cycles after ignored start", seen, cyc);
        end
        e = sb4.pop_front();
        n_tests++;
        if (d4 !== e.d[3:0] || bo4 !== e.bo || ovf4 !== e.ovf) begin
            n_fail++;
            $display("FAIL ignore_result: got d=%0d bo=%b ovf=%b, want d=%0d bo=%b ovf=%b",
                     d4, bo4, ovf4, e.d[3:0], e.bo, e.ovf);
        end
        drive4(5, 2, 0, 1'b1);
        n_tests++;
        if (busy4 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept: got busy=%b, want 1 after start in done cycle", busy4);
        end
        wait_done4(10, cyc, seen);
        n_tests++;
        if (!seen || cyc != 4) begin
            n_fail++;
            $display("FAIL b2b_latency: got seen=%b cycles=%0d, want done after 4", seen, cyc);
        end
        e = sb4.pop_front();
        n_tests++;
        if (d4 !== e.d[3:0] || bo4 !== e.bo || ovf4 !== e.ovf) begin
            n_fail++;
            $display("FAIL b2b_result: got d=%0d bo=%b ovf=%b, want d=%0d bo=%b ovf=%b",
                     d4, bo4, ovf4, e.d[3:0], e.bo, e.ovf);
        end
        wait_done4(6, cyc, seen);
        n_tests++;
        if (seen || sb4.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_extra_done: got extra done=%b pending=%0d, want none", seen, sb4.size());
        end
    endtask

    task automatic test_reset_abort;
        int   cyc;
        bit   seen;
        exp_t e;
        @(negedge clk);
        drive4(9, 3, 0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb4.delete();
        n_tests++;
        if ({busy4, done4, d4, bo4, ovf4} !== 8'h00) begin
            n_fail++;
            $display("FAIL abort_state: got busy=%b done=%b d=%0d bo=%b ovf=%b, want all 0",
                     busy4, done4, d4, bo4, ovf4);
        end
        wait_done4(8, cyc, seen);
        n_tests++;
        if (seen || busy4 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done: got done seen=%b busy=%b, want no done and idle", seen, busy4);
        end
        drive4(9, 3, 0, 1'b1);
        wait_done4(10, cyc, seen);
        e = sb4.pop_front();
        n_tests++;
        if (!seen || cyc != 4 || d4 !== e.d[3:0] || bo4 !== e.bo || ovf4 !== e.ovf) begin
            n_fail++;
            $display("FAIL abort_fresh: got seen=%b cycles=%0d d=%0d bo=%b ovf=%b, want 4 cycles d=%0d bo=%b ovf=%b",
                     seen, cyc, d4, bo4, ovf4, e.d[3:0], e.bo, e.ovf);
        end
    endtask

    task automatic test_width8;
        int   va[2] = '{8'h00, 8'h80};
        int   vb[2] = '{8'h01, 8'h01};
        int   cyc;
        bit   seen;
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive8(va[i], vb[i], 0);
            wait_done8(16, cyc, seen);
            n_tests++;
            if (!seen || cyc != 8) begin
                n_fail++;
                $display("FAIL w8_latency[%0d]: got seen=%b cycles=%0d, want done after 8", i, seen, cyc);
            end
            e = sb8.pop_front();
            n_tests++;
            if (d8 !== e.d || bo8 !== e.bo || ovf8 !== e.ovf) begin
                n_fail++;
                $display("FAIL w8_result[%0d]: got d=%h bo=%b ovf=%b, want d=%h bo=%b ovf=%b",
                         i, d8, bo8, ovf8, e.d, e.bo, e.ovf);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_reset_abort();
        test_width8();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
